stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Multi-register stack transfer sequencer for the V30-class execution unit. It expands a pre-decoded push/pop bitmask into an ordered stream of single-slot stack bus requests. Each request carries a slot index and a computed stack address, and the block returns the final SP. It generalises the fixed 16-bit STACK_* mask handling to a parametrised mask width, slot size and address width, and adds discard slots, backpressure and abort. It sits between the decoder's push/pop fields and the bus interface unit.

## Interface
- MASK_W, 16, number of mask bits / transferable slots; bit 0 is the first pushed and last popped.
- ADDR_W, 16, stack pointer and address width.
- STEP, 2, bytes per slot; SP adjust per slot.
- DISCARD_MASK, 16'h0020, slots that move SP but never issue a bus request.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sequence; accepted only while busy=0.
- is_pop  in  1  1 = pop sequence, 0 = push sequence; sampled with start.
- mask  in  MASK_W  slots to transfer; sampled with start.
- sp_in  in  ADDR_W  SP at sequence start; sampled with start.
- abort  in  1  synchronous cancel; has priority over every other input except reset.
- req_ready  in  1  bus unit accepts the current request.
- busy  out  1  high from the cycle after start until the cycle after done.
- req_valid  out  1  a request is presented.
- req_write  out  1  1 = push write, 0 = pop read.
- req_index  out  $clog2(MASK_W)  slot (register) index of the request.
- req_addr  out  ADDR_W  stack address of the request.
- sp_start  out  ADDR_W  SP captured at start, held until the next start (for pushing the original SP).
- sp_out  out  ADDR_W  running and final SP.
- done  out  1  single-cycle pulse when the sequence completes.

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - start=1 loads remaining←mask, dir←is_pop, sp_out←sp_in and sp_start←sp_in, then goes to ACTIVE.
  - start is ignored in ACTIVE and DONE.
- ACTIVE, slot selection:
  - Push selects the lowest set bit of remaining.
  - Pop selects the highest set bit of remaining.
  - Selection is combinational from remaining.
- ACTIVE, selected slot in DISCARD_MASK:
  - req_valid=0 and the slot bit is cleared this cycle.
  - sp_out is decremented by STEP on push or incremented by STEP on pop.
  - Costs one cycle.
- ACTIVE, other slots:
  - req_valid=1 and req_index = selected slot.
  - req_write=~dir.
  - req_addr = sp_out−STEP on push, sp_out on pop.
  - On a cycle with req_valid&req_ready: clear the bit, update sp_out as above, and re-evaluate next cycle.
  - Back-to-back requests are therefore possible.
- ACTIVE with remaining=0 goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic is modulo 2^ADDR_W; SP and address wrap silently.
- abort=1 in any state: next state IDLE, remaining cleared, no done pulse, sp_out holds its last value.
- If abort and req_ready are both high, the transfer counts as not taken; the bus unit must treat abort as cancelling it.

## Timing
- Reset values: busy=0, req_valid=0, req_write=0, req_index=0, req_addr=0, sp_start=0, sp_out=0, done=0; state IDLE.
- If reset_n deasserts mid-sequence, the block returns to IDLE immediately and no request or done is emitted.
- Start sampled at edge N gives busy=1 in cycle N+1.
  - The first request (or discard step) is presented in cycle N+1.
- While req_valid=1 and req_ready=0, req_index, req_addr and req_write are held stable and nothing changes.
- Cycle count for k requests with zero wait states and d discard slots: 1 (load) + k + d + 1 (DONE).
- mask=0: done in cycle N+2 with sp_out=sp_in and no request.
- req_* outputs are registered or derived only from state registers; there is no combinational path from req_ready to req_valid.

## Test plan
- Push, mask=0x01DF, sp_in=0x0100, req_ready=1 -> indices 0,1,2,3,4,6,7,8 at addrs 0x00FE,FC,FA,F8,F6,F4,F2,F0; req_write=1; sp_out=0x00F0; done in cycle N+10.
- Pop, mask=0x01EF, sp_in=0x00F0 -> indices 8,7,6 at 0x00F0,F2,F4; slot 5 discarded with no request (SP skips 0x00F6); then 3,2,1,0 at 0x00F8,FA,FC,FE; sp_out=0x0100.
- Push, mask=0x0001, sp_in=0x0000 -> one request at addr 0xFFFE; sp_out=0xFFFE, showing wrap.
- mask=0 -> no req_valid; done exactly 2 cycles after start; sp_out=sp_in; a second start during busy is ignored.
- Backpressure: push mask=0x0003, req_ready low 3 cycles on the first request -> index 0 and addr held stable for 4 cycles, then index 1 next cycle.
- Abort during the 2nd request (and separately reset_n low) -> req_valid=0 next cycle, no done, busy=0; a new start then runs normally.

Source files
------------

// File: rtl/stack_sequencer.sv
// Multi-register stack transfer sequencer: expands a push/pop slot mask into
// an ordered stream of single-slot stack bus requests and tracks the running SP.
module stack_sequencer #(
    parameter int                MASK_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter int                STEP         = 2,
    parameter logic [MASK_W-1:0] DISCARD_MASK = 16'h0020,
    localparam int               IDX_W        = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_pop,
    input  logic [MASK_W-1:0] mask,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic              abort,
    input  logic              req_ready,
    output logic              busy,
    output logic              req_valid,
    output logic              req_write,
    output logic [IDX_W-1:0]  req_index,
    output logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] sp_start,
    output logic [ADDR_W-1:0] sp_out,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(STEP);

    // Push drains from the lowest slot upward, pop from the highest slot downward.
    function automatic logic [IDX_W-1:0] pick_slot(input logic [MASK_W-1:0] vec,
                                                   input logic              pop);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (pop) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = MASK_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    state_t              state_r, state_nx_s;
    logic [MASK_W-1:0]   remaining_r, remaining_nx_s;
    logic                dir_r, dir_nx_s;
    logic [ADDR_W-1:0]   sp_out_r, sp_nx_s;
    logic [ADDR_W-1:0]   sp_start_r, sp_start_nx_s;
    logic                busy_r, done_r;
    logic                req_valid_r, req_valid_nx_s;
    logic                req_write_r, req_write_nx_s;
    logic [IDX_W-1:0]    req_index_r, req_index_nx_s;
    logic [ADDR_W-1:0]   req_addr_r, req_addr_nx_s;
    logic [IDX_W-1:0]    cur_slot_s, nx_slot_s;
    logic                advance_s;
    logic [ADDR_W-1:0]   sp_step_s;

    // Next-state, slot retirement and SP update for the current cycle.
    always_comb begin
        cur_slot_s     = pick_slot(remaining_r, dir_r);
        advance_s      = (|remaining_r) && (DISCARD_MASK[cur_slot_s] || req_ready);
        sp_step_s      = dir_r ? (sp_out_r + STEP_C) : (sp_out_r - STEP_C);
        state_nx_s     = state_r;
        remaining_nx_s = remaining_r;
        dir_nx_s       = dir_r;
        sp_nx_s        = sp_out_r;
        sp_start_nx_s  = sp_start_r;
        if (abort) begin
            state_nx_s     = ST_IDLE;
            remaining_nx_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx_s     = ST_ACTIVE;
                        remaining_nx_s = mask;
                        dir_nx_s       = is_pop;
                        sp_nx_s        = sp_in;
                        sp_start_nx_s  = sp_in;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (remaining_r == '0) begin
                        state_nx_s = ST_DONE;
                    end else if (advance_s) begin
                        remaining_nx_s = remaining_r & ~(MASK_W'(1'b1) << cur_slot_s);
                        sp_nx_s        = sp_step_s;
                    end else begin
                        state_nx_s = ST_ACTIVE;
                    end
                end
                ST_DONE: begin
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s     = ST_IDLE;
                    remaining_nx_s = '0;
                end
            endcase
        end
    end

    // Request fields for the next cycle, so the bus outputs leave flops directly.
    always_comb begin
        nx_slot_s      = pick_slot(remaining_nx_s, dir_nx_s);
        req_valid_nx_s = (state_nx_s == ST_ACTIVE) && (|remaining_nx_s) &&
                         !DISCARD_MASK[nx_slot_s];
        if (req_valid_nx_s) begin
            req_index_nx_s = nx_slot_s;
            req_write_nx_s = ~dir_nx_s;
            req_addr_nx_s  = dir_nx_s ? sp_nx_s : (sp_nx_s - STEP_C);
        end else begin
            req_index_nx_s = '0;
            req_write_nx_s = 1'b0;
            req_addr_nx_s  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            remaining_r <= '0;
            dir_r       <= 1'b0;
            sp_out_r    <= '0;
            sp_start_r  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            req_valid_r <= 1'b0;
            req_write_r <= 1'b0;
            req_index_r <= '0;
            req_addr_r  <= '0;
        end else begin
            state_r     <= state_nx_s;
            remaining_r <= remaining_nx_s;
            dir_r       <= dir_nx_s;
            sp_out_r    <= sp_nx_s;
            sp_start_r  <= sp_start_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            done_r      <= (state_nx_s == ST_DONE);
            req_valid_r <= req_valid_nx_s;
            req_write_r <= req_write_nx_s;
            req_index_r <= req_index_nx_s;
            req_addr_r  <= req_addr_nx_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign req_valid = req_valid_r;
    assign req_write = req_write_r;
    assign req_index = req_index_r;
    assign req_addr  = req_addr_r;
    assign sp_start  = sp_start_r;
    assign sp_out    = sp_out_r;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed scenarios plus random
// masks/backpressure compared against a slot-list reference model.
module tb_stack_sequencer;

    localparam int          MASK_W = 16;
    localparam int          ADDR_W = 16;
    localparam int          STEP   = 2;
    localparam logic [15:0] DISC   = 16'h0020;

    logic        clk = 1'b0;
    logic        reset_n, start, is_pop, abort, req_ready;
    logic [15:0] mask, sp_in;
    logic        busy, req_valid, req_write, done;
    logic [3:0]  req_index;
    logic [15:0] req_addr, sp_start, sp_out;

    stack_sequencer #(
        .MASK_W(MASK_W), .ADDR_W(ADDR_W), .STEP(STEP), .DISCARD_MASK(DISC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_pop(is_pop),
        .mask(mask), .sp_in(sp_in), .abort(abort), .req_ready(req_ready),
        .busy(busy), .req_valid(req_valid), .req_write(req_write),
        .req_index(req_index), .req_addr(req_addr), .sp_start(sp_start),
        .sp_out(sp_out), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [15:0] addr;
    } req_t;

    req_t        exp_q[$];
    logic [15:0] exp_sp;
    int          exp_slots;

    // Reference: walk the mask in transfer order, one SP step per set slot.
    task automatic build(input bit pop, input logic [15:0] m, input logic [15:0] sp);
        exp_q.delete();
        exp_sp    = sp;
        exp_slots = 0;
        for (int k = 0; k < MASK_W; k++) begin
            int s;
            s = pop ? (MASK_W - 1 - k) : k;
            if (m[s]) begin
                exp_slots++;
                if (!DISC[s]) begin
                    req_t r;
                    r.idx  = s;
                    r.addr = pop ? exp_sp : exp_sp - 16'(STEP);
                    exp_q.push_back(r);
                end
                exp_sp = pop ? exp_sp + 16'(STEP) : exp_sp - 16'(STEP);
            end
        end
    endtask

    function automatic bit ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        return (c > 3);
    endfunction

    // Start a sequence at edge N and follow it cycle by cycle until done.
    task automatic run_seq(input string name, input bit pop, input logic [15:0] m,
                           input logic [15:0] sp, input int mode, input bit stray);
        int          c, stalls, done_c;
        logic        pv, pr, pw;
        logic [3:0]  pidx;
        logic [15:0] paddr;
        req_t        r;
        build(pop, m, sp);
        @(negedge clk);
        start = 1'b1; is_pop = pop; mask = m; sp_in = sp;
        @(negedge clk);
        start = 1'b0;
        c = 1; stalls = 0; done_c = 0; pv = 1'b0; pr = 1'b1;
        pw = 1'b0; pidx = '0; paddr = '0;
        chk({name, "/busy"}, busy, 1);
        chk({name, "/sp_start"}, sp_start, sp);
        while (c < 400 && done_c == 0) begin
            req_ready = ready_for(mode, c);
            if (pv && !pr) begin
                chk({name, "/hold_valid"}, req_valid, 1);
                chk({name, "/hold_index"}, req_index, pidx);
                chk({name, "/hold_addr"}, req_addr, paddr);
                chk({name, "/hold_write"}, req_write, pw);
            end
            if (req_valid) begin
                if (exp_q.size() == 0) begin
                    chk({name, "/extra_req"}, req_valid, 0);
                end else if (req_ready) begin
                    r = exp_q.pop_front();
                    chk({name, "/index"}, req_index, r.idx);
                    chk({name, "/addr"}, req_addr, r.addr);
                    chk({name, "/write"}, req_write, 32'(!pop));
                end else begin
                    stalls++;
                end
            end
            if (done) done_c = c;
            pv = req_valid; pr = req_ready; pidx = req_index; paddr = req_addr; pw = req_write;
            if (stray && c == 1) begin
                start = 1'b1; mask = 16'hFFFF; sp_in = 16'h1234; is_pop = ~pop;
            end else begin
                start = 1'b0;
            end
            if (done_c == 0) begin
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        chk({name, "/done_seen"}, 32'(done_c != 0), 1);
        chk({name, "/done_cycle"}, done_c, 2 + exp_slots + stalls);
        chk({name, "/missing_reqs"}, exp_q.size(), 0);
        chk({name, "/sp_out"}, sp_out, exp_sp);
        @(negedge clk);
        chk({name, "/done_pulse"}, done, 0);
        chk({name, "/busy_after"}, busy, 0);
        chk({name, "/valid_after"}, req_valid, 0);
        chk({name, "/sp_start_held"}, sp_start, sp);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; is_pop = 1'b0; abort = 1'b0; req_ready = 1'b1;
        mask = '0; sp_in = '0;
        repeat (2) @(negedge clk);
        chk("rst/busy", busy, 0);
        chk("rst/valid", req_valid, 0);
        chk("rst/write", req_write, 0);
        chk("rst/index", req_index, 0);
        chk("rst/addr", req_addr, 0);
        chk("rst/sp_start", sp_start, 0);
        chk("rst/sp_out", sp_out, 0);
        chk("rst/done", done, 0);
        reset_n = 1'b1;

        run_seq("push_1df", 1'b0, 16'h01DF, 16'h0100, 0, 1'b0);
        chk("push_1df/final_sp", sp_out, 16'h00F0);
        run_seq("pop_1ef", 1'b1, 16'h01EF, 16'h00F0, 0, 1'b0);
        chk("pop_1ef/final_sp", sp_out, 16'h0100);
        run_seq("push_wrap", 1'b0, 16'h0001, 16'h0000, 0, 1'b0);
        chk("push_wrap/final_sp", sp_out, 16'hFFFE);
        run_seq("mask0", 1'b0, 16'h0000, 16'h4321, 0, 1'b1);
        run_seq("backpress", 1'b0, 16'h0003, 16'h0200, 2, 1'b0);

        // Abort while the second request is presented.
        @(negedge clk);
        start = 1'b1; is_pop = 1'b0; mask = 16'h000F; sp_in = 16'h0300; req_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort/req1_index", req_index, 0);
        @(negedge clk);
        chk("abort/req2_valid", req_valid, 1);
        chk("abort/req2_index", req_index, 1);
        chk("abort/req2_addr", req_addr, 16'h02FC);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort/valid", req_valid, 0);
        chk("abort/busy", busy, 0);
        chk("abort/done", done, 0);
        chk("abort/sp_hold", sp_out, 16'h02FE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort/no_done", done, 0);
            chk("abort/quiet", req_valid, 0);
        end
        run_seq("after_abort", 1'b1, 16'h0031, 16'h0400, 0, 1'b0);

        // Asynchronous reset mid-sequence.
        @(negedge clk);
        start = 1'b1; is_pop = 1'b0; mask = 16'h000F; sp_in = 16'h0200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst/valid", req_valid, 0);
        chk("mid_rst/busy", busy, 0);
        chk("mid_rst/sp_out", sp_out, 0);
        chk("mid_rst/done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst/no_done", done, 0);
            chk("mid_rst/quiet", req_valid, 0);
        end
        run_seq("after_rst", 1'b0, 16'h8421, 16'h0010, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic [15:0] rm, rs;
            logic        rp;
            rm = 16'($urandom);
            rs = 16'($urandom);
            rp = 1'($urandom_range(0, 1));
            run_seq("random", rp, rm, rs, 1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
